// File: rtl/fifo_pkg.sv
// Shared defaults for the show-ahead FIFO.
// Contents:
//   FIFO_DATA_WIDTH - default stored word width
//   FIFO_DEPTH      - default entry count (power of two, >= 2)
//   fifo_addr_w     - address width for a given depth
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/async_fifo_if.sv
// Producer/consumer bundle for the show-ahead FIFO.
// Signals:
//   w_en, data_in   - write request and its data
//   r_en            - pop request for the head word
//   data_out        - head word, valid whenever empty is low
//   full, empty     - flow-control flags
// Handshake: a write is taken on a rising edge where w_en=1 and full=0;
// a pop is taken on a rising edge where r_en=1 and empty=0. Requests made
// against the opposite flag are silently dropped. Both flags are sampled
// as they stand before the edge, so a simultaneous write and pop are
// judged independently.
// Modports:
//   master - the producer/consumer side
//   slave  - the FIFO side
interface async_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, full, empty
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, full, empty
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// combinational read port; every entry is cleared by a synchronous reset.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   we_i, waddr_i    - write enable and address
//   wdata_i          - write data
//   raddr_i          - read address
//   rdata_o          - read data (no latency)
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with a first-word-fall-through read port.
// The head word is presented on data_out combinationally; a pop simply
// advances the read pointer so the next word appears after that edge.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-high reset; clears pointers and storage
//   bus  - async_fifo_if slave: w_en/data_in, r_en/data_out, full/empty
module async_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input logic          clk,
  input logic          rst,
  async_fifo_if.slave  bus
);

  localparam int ADDR_WIDTH = fifo_addr_w(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  full, empty;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  // Each side is judged on its own pre-edge flag, so a full FIFO still
  // pops and an empty FIFO still accepts on a simultaneous request.
  assign wr_accept = bus.w_en && !full;
  assign rd_accept = bus.r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  assign bus.data_out = rdata;
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  async_fifo_if #(.DATA_WIDTH(DW)) bus ();

  async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  // Contents as an ordered list of words; flags follow from its length.
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- driver ----------------
  // Drive one cycle of requests, update the model with the rules as seen
  // before the edge, then settle #1 after the edge for checking.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bit can_w;
    bit can_r;
    bus.w_en    = w;
    bus.data_in = d;
    bus.r_en    = r;
    can_w = (exp_q.size() < DEPTH);
    can_r = (exp_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (r && can_r) void'(exp_q.pop_front());
      if (w && can_w) exp_q.push_back(d);
    end
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b1);
    rst = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
    checks++;
    if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
    checks++;
    if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", bus.data_out); end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_idle_empty got=%0b exp=1", bus.empty); end
  endtask

  task automatic test_single();
    step(1'b1, 8'hA5, 1'b0);
    checks++;
    if (bus.empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%0b exp=0", bus.empty); end
    checks++;
    if (bus.data_out !== 8'hA5) begin failures++; $display("FAIL single_data got=%02h exp=a5", bus.data_out); end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%0b exp=1", bus.empty); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] v;
    for (int i = 1; i <= DEPTH; i++) begin
      v = DW'(i);
      checks++;
      if (bus.full !== 1'b0) begin failures++; $display("FAIL fill_early_full i=%0d got=%0b exp=0", i, bus.full); end
      step(1'b1, v, 1'b0);
    end
    checks++;
    if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
    step(1'b1, 8'hFF, 1'b0);
    checks++;
    if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_overflow_full got=%0b exp=1", bus.full); end
    for (int i = 1; i <= DEPTH; i++) begin
      v = DW'(i);
      checks++;
      if (bus.data_out !== v) begin failures++; $display("FAIL fill_drain_data i=%0d got=%02h exp=%02h", i, bus.data_out, v); end
      step(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL fill_drain_empty got=%0b exp=1", bus.empty); end
    checks++;
    if (bus.full !== 1'b0) begin failures++; $display("FAIL fill_drain_full got=%0b exp=0", bus.full); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
      end else begin
        checks++;
        if (bus.data_out !== exp_q[0]) begin failures++; $display("FAIL wrap_data i=%0d got=%02h exp=%02h", i, bus.data_out, exp_q[0]); end
        step(1'b0, 8'h00, 1'b1);
      end
      checks++;
      if (bus.empty !== (exp_q.size() == 0)) begin failures++; $display("FAIL wrap_empty i=%0d got=%0b exp=%0b", i, bus.empty, exp_q.size() == 0); end
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] head;
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    head = exp_q[1];
    step(1'b1, DW'($urandom_range(0, 255)), 1'b1);
    checks++;
    if (exp_q.size() != 3 || bus.data_out !== head) begin
      failures++; $display("FAIL simul_mid data got=%02h exp=%02h occ=%0d", bus.data_out, head, exp_q.size());
    end
    checks++;
    if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin failures++; $display("FAIL simul_mid_flags got=%0b%0b exp=00", bus.empty, bus.full); end
    while (exp_q.size() < DEPTH) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    checks++;
    if (bus.full !== 1'b1) begin failures++; $display("FAIL simul_fill_full got=%0b exp=1", bus.full); end
    step(1'b1, 8'hEE, 1'b1);
    checks++;
    if (bus.full !== 1'b0) begin failures++; $display("FAIL simul_full_read_only got=%0b exp=0", bus.full); end
    while (exp_q.size() > 0) begin
      checks++;
      if (bus.data_out !== exp_q[0]) begin failures++; $display("FAIL simul_drain_data got=%02h exp=%02h", bus.data_out, exp_q[0]); end
      step(1'b0, 8'h00, 1'b1);
    end
    step(1'b1, 8'h5A, 1'b1);
    checks++;
    if (bus.empty !== 1'b0 || bus.data_out !== 8'h5A) begin
      failures++; $display("FAIL simul_empty_write_only empty=%0b data=%02h exp=0/5a", bus.empty, bus.data_out);
    end
  endtask

  task automatic test_reset_midstream();
    while (exp_q.size() < 5) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%0b%0b exp=10", bus.empty, bus.full); end
    checks++;
    if (bus.data_out !== 8'h00) begin failures++; $display("FAIL midrst_data got=%02h exp=00", bus.data_out); end
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h4D, 1'b0);
    checks++;
    if (bus.data_out !== 8'h3C) begin failures++; $display("FAIL midrst_first got=%02h exp=3c", bus.data_out); end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.data_out !== 8'h4D) begin failures++; $display("FAIL midrst_second got=%02h exp=4d", bus.data_out); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      checks++;
      if (bus.empty !== (exp_q.size() == 0) || bus.full !== (exp_q.size() == DEPTH)) begin
        failures++; $display("FAIL rand_flags i=%0d got=%0b%0b occ=%0d", i, bus.empty, bus.full, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (bus.data_out !== exp_q[0]) begin failures++; $display("FAIL rand_data i=%0d got=%02h exp=%02h", i, bus.data_out, exp_q[0]); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
